// File: rtl/thc_tx_sched.sv
// thc_tx_sched: two-requester round-robin scheduler and MSB-first serializer
// wrapped around an external combinational 32->38 Hamming encoder (THC).
// Ports:
//   clk, rst_n                      clock and synchronous active-low reset
//   reqN_valid/reqN_data/reqN_ready requester handshakes (ready is combinational)
//   enc_data_in / enc_data_out      registered word to the encoder / codeword return
//   ser_en                          sink enable; low stalls shifting
//   ser_out/ser_valid/ser_sof/ser_eof serial codeword bit with frame markers
//   grant_id, busy                  requester in flight; high outside IDLE
module thc_tx_sched #(
  parameter int DATA_W     = 32,
  parameter int CODE_W     = 38,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [DATA_W-1:0] enc_data_in,
  input  logic [CODE_W-1:0] enc_data_out,
  input  logic              ser_en,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              ser_sof,
  output logic              ser_eof,
  output logic              grant_id,
  output logic              busy
);

  localparam int BCW = (CODE_W > 2) ? $clog2(CODE_W) : 1;
  localparam int GCW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [BCW-1:0] BC_TOP  = BCW'(CODE_W - 1);
  localparam logic [GCW-1:0] GAP_TOP = (GAP_CYCLES > 0) ? GCW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               ptr_q, ptr_d;      // 0: requester 0 wins a tie
  logic               gid_q, gid_d;
  logic [DATA_W-1:0]  enc_q, enc_d;
  logic [CODE_W-1:0]  shift_q, shift_d;
  logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [GCW-1:0]     gap_cnt_q, gap_cnt_d;
  logic               gnt0, gnt1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= 1'b0;
      gid_q     <= 1'b0;
      enc_q     <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gid_q     <= gid_d;
      enc_q     <= enc_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gid_d     = gid_q;
    enc_d     = enc_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    gnt0      = 1'b0;
    gnt1      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Requester 1 wins when alone, or on a tie when the pointer favours it.
        gnt1 = req1_valid & (~req0_valid | ptr_q);
        gnt0 = req0_valid & ~gnt1;
        if (gnt0 | gnt1) begin
          enc_d   = gnt1 ? req1_data : req0_data;
          gid_d   = gnt1;
          ptr_d   = ~gnt1;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        // enc_q has been stable for a full cycle, so the encoder output is settled.
        shift_d   = enc_data_out;
        bit_cnt_d = BC_TOP;
        state_d   = S_SHIFT;
      end

      S_SHIFT: begin
        if (ser_en) begin
          shift_d = {shift_q[CODE_W-2:0], 1'b0};
          if (bit_cnt_q == '0) begin
            if (GAP_CYCLES > 0) begin
              gap_cnt_d = GAP_TOP;
              state_d   = S_GAP;
            end else begin
              state_d   = S_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q - BCW'(1);
          end
        end
      end

      S_GAP: begin
        // Gap timing ignores ser_en: the idle spacing is in clocks, not bits.
        if (gap_cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GCW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Readies are masked while reset is asserted so nothing looks accepted.
  assign req0_ready  = rst_n & gnt0;
  assign req1_ready  = rst_n & gnt1;
  assign enc_data_in = enc_q;
  assign grant_id    = gid_q;
  assign busy        = (state_q != S_IDLE);
  assign ser_valid   = (state_q == S_SHIFT);
  assign ser_out     = ser_valid & shift_q[CODE_W-1];
  assign ser_sof     = ser_valid & (bit_cnt_q == BC_TOP);
  assign ser_eof     = ser_valid & (bit_cnt_q == '0);

endmodule

// File: tb/tb_thc_tx_sched.sv
// Bench for thc_tx_sched: default build (GAP_CYCLES=2) plus a GAP_CYCLES=0 build,
// each fed by a combinational Hamming-style encoder model.
module tb_thc_tx_sched;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_data, req1_data, enc_data_in;
  logic [37:0] enc_data_out;
  logic        ser_en, ser_out, ser_valid, ser_sof, ser_eof, grant_id, busy;

  logic        g_req0_valid, g_req1_valid, g_req0_ready, g_req1_ready;
  logic [31:0] g_req0_data, g_req1_data, g_enc_data_in;
  logic [37:0] g_enc_data_out;
  logic        g_ser_en, g_ser_out, g_ser_valid, g_ser_sof, g_ser_eof, g_grant_id, g_busy;

  int total = 0;
  int bad   = 0;

  // 32 data bits followed by 6 parity bits; parity i covers data bit j when bit i of (j+1) is set.
  function automatic logic [37:0] enc_model(input logic [31:0] d);
    logic [5:0] p;
    p = '0;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 32; j++)
        if ((((j + 1) >> i) & 1) == 1) p[i] = p[i] ^ d[j];
    return {d, p};
  endfunction

  assign enc_data_out   = enc_model(enc_data_in);
  assign g_enc_data_out = enc_model(g_enc_data_in);

  thc_tx_sched #(.DATA_W(32), .CODE_W(38), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .enc_data_in(enc_data_in), .enc_data_out(enc_data_out),
    .ser_en(ser_en), .ser_out(ser_out), .ser_valid(ser_valid),
    .ser_sof(ser_sof), .ser_eof(ser_eof), .grant_id(grant_id), .busy(busy)
  );

  thc_tx_sched #(.DATA_W(32), .CODE_W(38), .GAP_CYCLES(0)) dut_nogap (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(g_req0_valid), .req0_data(g_req0_data), .req0_ready(g_req0_ready),
    .req1_valid(g_req1_valid), .req1_data(g_req1_data), .req1_ready(g_req1_ready),
    .enc_data_in(g_enc_data_in), .enc_data_out(g_enc_data_out),
    .ser_en(g_ser_en), .ser_out(g_ser_out), .ser_valid(g_ser_valid),
    .ser_sof(g_ser_sof), .ser_eof(g_ser_eof), .grant_id(g_grant_id), .busy(g_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered at the sample point of the accept cycle T for requester gid.
  // Returns at the sample point of the following IDLE cycle, or early at bit abort_at.
  task automatic frame(input logic [31:0] w, input logic gid, input int stall_at,
                       input int stall_len, input int abort_at);
    logic [37:0] exp;
    int idx, cyc, stall_left, eof_cyc;
    bit stalled;
    exp = enc_model(w);
    tick;
    if (gid) req1_valid = 1'b0; else req0_valid = 1'b0;
    #1;
    chk("load_busy", busy, 1);
    chk("load_vld", ser_valid, 0);
    chk("load_gid", grant_id, gid);
    chk("load_enc", enc_data_in, w);
    chk("load_rdy", {req1_ready, req0_ready}, 0);
    idx = 37; cyc = 1; stall_left = 0; stalled = 0; eof_cyc = -1;
    while (idx >= 0 && cyc < 120) begin
      tick;
      cyc++;
      if (idx == stall_at && !stalled) begin
        stalled = 1;
        stall_left = stall_len;
      end
      ser_en = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      #1;
      chk("ser_vld", ser_valid, 1);
      chk("ser_bit", ser_out, exp[idx]);
      chk("sof", ser_sof, idx == 37);
      chk("eof", ser_eof, idx == 0);
      if (idx == abort_at) return;
      if (idx == 0 && ser_en) eof_cyc = cyc;
      if (ser_en) idx--;
    end
    if (cyc >= 120) chk("frame_timeout", 1, 0);
    chk("eof_cycle", eof_cyc, 39 + stall_len);
    for (int g = 0; g < 2; g++) begin
      tick;
      ser_en = 1'b0;
      #1;
      chk("gap_vld", ser_valid, 0);
      chk("gap_out", ser_out, 0);
      chk("gap_busy", busy, 1);
      chk("gap_rdy", {req1_ready, req0_ready}, 0);
    end
    tick;
    ser_en = 1'b1;
    #1;
    chk("idle_busy", busy, 0);
  endtask

  int e, r2, s2;

  initial begin
    rst_n = 1'b0; ser_en = 1'b1;
    req0_valid = 1'b1; req0_data = 32'hCAFE3475;
    req1_valid = 1'b0; req1_data = '0;
    g_req0_valid = 1'b0; g_req0_data = '0;
    g_req1_valid = 1'b0; g_req1_data = '0;
    g_ser_en = 1'b1;

    // Reset held for three clocks with a pending request.
    repeat (3) tick;
    #1;
    chk("rst_rdy", {req1_ready, req0_ready}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ser", {ser_valid, ser_out, ser_sof, ser_eof}, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_enc", enc_data_in, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_rdy0", req0_ready, 1);
    chk("post_rst_rdy1", req1_ready, 0);
    frame(32'hCAFE3475, 1'b0, -1, 0, -1);

    // Stall of 5 cycles at bit_cnt 20 on a requester-1 frame.
    req1_valid = 1'b1; req1_data = 32'h5A5A0F0F;
    #1;
    chk("stall_rdy1", req1_ready, 1);
    chk("stall_rdy0", req0_ready, 0);
    frame(32'h5A5A0F0F, 1'b1, 20, 5, -1);

    // Contention: pointer now favours requester 0.
    req0_valid = 1'b1; req0_data = 32'hCAFE3475;
    req1_valid = 1'b1; req1_data = 32'h00000001;
    #1;
    chk("cont1_rdy0", req0_ready, 1);
    chk("cont1_rdy1", req1_ready, 0);
    frame(32'hCAFE3475, 1'b0, -1, 0, -1);
    chk("cont2_rdy1", req1_ready, 1);
    chk("cont2_rdy0", req0_ready, 0);
    frame(32'h00000001, 1'b1, -1, 0, -1);
    req0_valid = 1'b1; req0_data = 32'hABCD0000;
    req1_valid = 1'b1; req1_data = 32'h00000002;
    #1;
    chk("cont3_rdy0", req0_ready, 1);
    chk("cont3_rdy1", req1_ready, 0);
    frame(32'hABCD0000, 1'b0, -1, 0, -1);

    // Requester 1 still waiting; abandon its frame by reset at bit_cnt 10.
    chk("abort_rdy1", req1_ready, 1);
    frame(32'h00000002, 1'b1, -1, 0, 10);
    rst_n = 1'b0;
    tick;
    #1;
    chk("abort_vld", ser_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_eof", ser_eof, 0);
    chk("abort_gid", grant_id, 0);
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_data = 32'hFFFFFFFF;
    #1;
    chk("after_abort_rdy0", req0_ready, 1);
    frame(32'hFFFFFFFF, 1'b0, -1, 0, -1);

    // Zero-gap build: back-to-back frames from requester 0.
    g_req0_valid = 1'b1; g_req0_data = 32'h00000000;
    #1;
    chk("ng_rdy_first", g_req0_ready, 1);
    e = -1; r2 = -1; s2 = -1;
    for (int c = 1; c <= 50; c++) begin
      tick;
      if (c == 1) g_req0_data = 32'hFFFFFFFF;
      if (r2 > 0 && c == r2 + 1) g_req0_valid = 1'b0;
      #1;
      if (g_ser_eof && e < 0) e = c;
      if (g_req0_ready && r2 < 0) r2 = c;
      if (g_ser_sof && e >= 0 && s2 < 0) begin
        s2 = c;
        chk("ng_sof_bit", g_ser_out, 1);
      end
    end
    chk("ng_eof_cycle", e, 39);
    chk("ng_rdy2_cycle", r2, 40);
    chk("ng_sof2_cycle", s2, 42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
